// File: rtl/somador_serial.sv
// rtl/somador_serial.sv - bit-serial WIDTH-bit adder, one full-adder cell per clock
// Optional subtract mode (a - b, c = borrow) enabled by defining SOMADOR_SUB_EN.
module somador_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SOMADOR_SUB_EN
  input  logic             op,
`endif
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_q;
  logic             op_eff;
  logic             sum;
  logic             carry_nxt;

`ifdef SOMADOR_SUB_EN
  assign op_eff = op;
`else
  assign op_eff = 1'b0;
`endif

  // The single full-adder cell shared by every bit position
  always_comb begin
    sum       = ra[0] ^ rb[0] ^ carry;
    carry_nxt = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rr    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      s     <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1
            ra    <= a;
            rb    <= op_eff ? ~b : b;
            carry <= op_eff;
            sub_q <= op_eff;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          ra    <= {1'b0, ra[WIDTH-1:1]};
          rb    <= {1'b0, rb[WIDTH-1:1]};
          rr    <= {sum, rr[WIDTH-1:1]};
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            s     <= {sum, rr[WIDTH-1:1]};
            c     <= carry_nxt ^ sub_q;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
